// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_unit : multicycle RV64I control sequencer for the cpu datapath     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module control_unit #(
  parameter int                  WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [WORDSIZE-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  input  logic                alu_zero,
  output logic [4:0]          cpu_rf_addr_a,
  output logic [4:0]          cpu_rf_addr_b,
  output logic [4:0]          cpu_rf_write_addr,
  output logic                cpu_rf_write_en,
  output logic [WORDSIZE-1:0] cpu_immediate,
  output logic                cpu_mux_0_sel,
  output logic                cpu_mux_1_sel,
  output logic                cpu_mux_2_sel,
  output logic [2:0]          cpu_alu_operation,
  output logic                cpu_dm_write_en,
  output logic                illegal_instr
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  localparam logic [WORDSIZE-1:0] PC_STEP = WORDSIZE'(4);

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [WORDSIZE-1:0] imm_i, imm_s, imm_b, imm;
  logic                legal, is_load, is_store, is_branch;
  logic                mux1, mux2;
  logic [2:0]          alu_op;
  logic                req, rf_we, dm_we;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{(WORDSIZE-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{(WORDSIZE-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  // Decode is purely a function of IR, so outputs hold until the next ack.
  always_comb begin
    legal     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    mux1      = 1'b0;
    mux2      = 1'b0;
    alu_op    = 3'b000;
    imm       = '0;
    case (opcode)
      7'b0110011: begin
        mux1 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: begin legal = 1'b1; alu_op = 3'b000; end
          10'b0100000_000: begin legal = 1'b1; alu_op = 3'b001; end
          10'b0000000_111: begin legal = 1'b1; alu_op = 3'b010; end
          10'b0000000_110: begin legal = 1'b1; alu_op = 3'b011; end
          10'b0000000_100: begin legal = 1'b1; alu_op = 3'b100; end
          default: ;
        endcase
      end
      7'b0010011: begin
        imm = imm_i;
        case (funct3)
          3'b000: begin legal = 1'b1; alu_op = 3'b000; end
          3'b111: begin legal = 1'b1; alu_op = 3'b010; end
          3'b110: begin legal = 1'b1; alu_op = 3'b011; end
          3'b100: begin legal = 1'b1; alu_op = 3'b100; end
          default: ;
        endcase
      end
      7'b0000011: begin
        imm     = imm_i;
        mux2    = 1'b1;
        legal   = (funct3 == 3'b011);
        is_load = 1'b1;
      end
      7'b0100011: begin
        imm      = imm_s;
        legal    = (funct3 == 3'b011);
        is_store = 1'b1;
      end
      7'b1100011: begin
        imm       = imm_b;
        mux1      = 1'b1;
        alu_op    = 3'b001;
        legal     = (funct3 == 3'b000);
        is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    req       = 1'b0;
    rf_we     = 1'b0;
    dm_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_d    = pc_q + (alu_zero ? imm : PC_STEP);
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (is_store) begin
          dm_we   = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        rf_we   = (ir_q[11:7] != 5'd0);
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Enables are masked in the reset cycle so an aborted instruction never writes.
  assign imem_req          = req & ~rst;
  assign cpu_rf_write_en   = rf_we & ~rst;
  assign cpu_dm_write_en   = dm_we & ~rst;
  assign imem_addr         = pc_q;
  assign cpu_rf_addr_a     = ir_q[19:15];
  assign cpu_rf_addr_b     = ir_q[24:20];
  assign cpu_rf_write_addr = ir_q[11:7];
  assign cpu_immediate     = imm;
  assign cpu_mux_0_sel     = 1'b0;
  assign cpu_mux_1_sel     = mux1;
  assign cpu_mux_2_sel     = mux2;
  assign cpu_alu_operation = alu_op;
  assign illegal_instr     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_unit : directed + randomized bench against an instruction model |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        alu_zero = 1'b0;
  logic [4:0]  rf_a, rf_b, rf_wa;
  logic        rf_we, dm_we;
  logic [63:0] imm;
  logic        m0, m1, m2;
  logic [2:0]  aluop;
  logic        illegal;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] m_pc   = '0;

  always #5 clk = ~clk;

  control_unit #(.WORDSIZE(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_zero(alu_zero),
    .cpu_rf_addr_a(rf_a), .cpu_rf_addr_b(rf_b), .cpu_rf_write_addr(rf_wa),
    .cpu_rf_write_en(rf_we), .cpu_immediate(imm),
    .cpu_mux_0_sel(m0), .cpu_mux_1_sel(m1), .cpu_mux_2_sel(m2),
    .cpu_alu_operation(aluop), .cpu_dm_write_en(dm_we), .illegal_instr(illegal)
  );

  // kind: 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch
  typedef struct packed {
    logic        legal;
    logic [2:0]  kind;
    logic [63:0] imm;
    logic [2:0]  op;
    logic        m1;
    logic        m2;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (r >= (64'sd1 <<< (bits - 1))) r = r - (64'sd1 <<< bits);
    return 64'(r);
  endfunction

  function automatic exp_t model(input logic [31:0] ir);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    longint      iv, sv, bv;
    e   = '0;
    opc = ir[6:0];
    f3  = ir[14:12];
    f7  = ir[31:25];
    iv  = longint'(ir[31:20]);
    sv  = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
    bv  = longint'(ir[31]) * 4096 + longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
    case (opc)
      7'h33: begin
        e.kind = 3'd0; e.m1 = 1'b1;
        if (f7 == 7'h00 && f3 == 3'd0) begin e.legal = 1'b1; e.op = 3'd0; end
        if (f7 == 7'h20 && f3 == 3'd0) begin e.legal = 1'b1; e.op = 3'd1; end
        if (f7 == 7'h00 && f3 == 3'd7) begin e.legal = 1'b1; e.op = 3'd2; end
        if (f7 == 7'h00 && f3 == 3'd6) begin e.legal = 1'b1; e.op = 3'd3; end
        if (f7 == 7'h00 && f3 == 3'd4) begin e.legal = 1'b1; e.op = 3'd4; end
      end
      7'h13: begin
        e.kind = 3'd1; e.imm = sext(iv, 12);
        if (f3 == 3'd0) begin e.legal = 1'b1; e.op = 3'd0; end
        if (f3 == 3'd7) begin e.legal = 1'b1; e.op = 3'd2; end
        if (f3 == 3'd6) begin e.legal = 1'b1; e.op = 3'd3; end
        if (f3 == 3'd4) begin e.legal = 1'b1; e.op = 3'd4; end
      end
      7'h03: begin e.kind = 3'd2; e.imm = sext(iv, 12); e.legal = (f3 == 3'd3); e.m2 = 1'b1; end
      7'h23: begin e.kind = 3'd3; e.imm = sext(sv, 12); e.legal = (f3 == 3'd3); end
      7'h63: begin e.kind = 3'd4; e.imm = sext(bv, 13); e.legal = (f3 == 3'd0); e.op = 3'd1; e.m1 = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          kind, sel;
    r    = $urandom;
    rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : r[11:7];
    kind = $urandom_range(0, 4);
    sel  = $urandom_range(0, 4);
    f7   = 7'h00;
    case (sel)
      0: f3 = 3'd0;
      1: begin f3 = 3'd0; f7 = 7'h20; end
      2: f3 = 3'd7;
      3: f3 = 3'd6;
      default: f3 = 3'd4;
    endcase
    case (kind)
      0:       return {f7, r[24:20], r[19:15], f3, rd, 7'h33};
      1:       return {r[31:20], r[19:15], f3, rd, 7'h13};
      2:       return {r[31:20], r[19:15], 3'd3, rd, 7'h03};
      3:       return {r[31:25], r[24:20], r[19:15], 3'd3, r[11:7], 7'h23};
      default: return {r[31:25], r[24:20], r[19:15], 3'd0, r[11:7], 7'h63};
    endcase
  endfunction

  task automatic do_reset(input int n);
    rst      = 1'b1;
    imem_ack = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_we", {rf_we, dm_we}, 2'b00);
    end
    rst  = 1'b0;
    m_pc = 64'd0;
    #1;
    chk("rst_fetch", {imem_req, illegal, imem_addr}, {1'b1, 1'b0, 64'd0});
    chk("rst_outs", {rf_a, rf_b, rf_wa, imm, m0, m1, m2, aluop}, '0);
  endtask

  task automatic do_ack(input logic [31:0] ir, input int delay);
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, m_pc);
    repeat (delay) begin
      imem_ack  = 1'b0;
      imem_data = $urandom;
      @(negedge clk); #1;
      chk("hold_req_addr", {imem_req, imem_addr}, {1'b1, m_pc});
    end
    imem_ack  = 1'b1;
    imem_data = ir;
    @(negedge clk); #1;
    imem_ack  = 1'b0;
    imem_data = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit zero, input int delay);
    exp_t e;
    int   lat, rf_cnt, rf_at, dm_cnt, dm_at, exp_lat;
    bit   stable;
    e = model(ir);
    do_ack(ir, delay);
    alu_zero = zero;
    lat = 0; rf_cnt = 0; rf_at = -1; dm_cnt = 0; dm_at = -1; stable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (imem_req) break;
      lat++;
      if (k == 1) begin
        chk("rs1", rf_a, ir[19:15]);
        chk("aluop", aluop, e.op);
        chk("mux01", {m0, m1}, {1'b0, e.m1});
        if (e.kind == 0 || e.kind >= 3) chk("rs2", rf_b, ir[24:20]);
        if (e.kind <= 2) chk("rd_mux2", {rf_wa, m2}, {ir[11:7], e.m2});
        if (e.kind != 0) chk("imm", imm, e.imm);
      end
      if (aluop !== e.op || m1 !== e.m1 || rf_a !== ir[19:15] || (e.kind != 0 && imm !== e.imm))
        stable = 1'b0;
      if (rf_we) begin rf_cnt++; rf_at = k; end
      if (dm_we) begin dm_cnt++; dm_at = k; end
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      @(negedge clk); #1;
    end
    imem_ack = 1'b0;
    case (e.kind)
      3'd2:    exp_lat = 4;
      3'd4:    exp_lat = 2;
      default: exp_lat = 3;
    endcase
    chk("latency", lat, exp_lat);
    chk("decode_stable", stable, 1'b1);
    chk("rf_pulses", rf_cnt, (e.kind <= 2 && ir[11:7] != 5'd0) ? 1 : 0);
    if (rf_cnt == 1) chk("rf_pulse_cycle", rf_at, exp_lat);
    chk("dm_pulses", dm_cnt, (e.kind == 3) ? 1 : 0);
    if (dm_cnt == 1) chk("dm_pulse_cycle", dm_at, 3);
    if (e.kind == 4 && zero) m_pc = m_pc + e.imm;
    else                     m_pc = m_pc + 64'd4;
    chk("next_addr", {imem_req, imem_addr}, {1'b1, m_pc});
  endtask

  task automatic run_trap(input logic [31:0] ir);
    bit ok;
    do_ack(ir, 0);
    ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (imem_req || rf_we || dm_we) ok = 1'b0;
      if (k >= 2 && !illegal) ok = 1'b0;
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      @(negedge clk); #1;
    end
    imem_ack = 1'b0;
    chk("trap_hold", ok, 1'b1);
    chk("trap_flag_pc", {illegal, imem_req, imem_addr}, {1'b1, 1'b0, m_pc});
    do_reset(1);
  endtask

  initial begin
    logic [31:0] r;
    do_reset(2);

    run_instr(32'h00500093, 1'b0, 0);   // addi x1,x0,5
    run_instr(32'h002081B3, 1'b1, 0);   // add x3,x1,x2
    run_instr(32'h0080B283, 1'b0, 0);   // ld x5,8(x1)
    run_instr(32'h0020B823, 1'b1, 5);   // sd x2,16(x1)
    chk("pc_before_beq", m_pc, 64'h10);
    run_instr(32'h00208463, 1'b1, 0);   // beq taken -> 0x18
    run_instr(32'h00208463, 1'b0, 1);   // beq not taken -> 0x1c
    run_instr(32'h00000013, 1'b0, 0);   // addi x0: no write pulse

    for (int i = 0; i < 60; i++)
      run_instr(gen_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Reset in WRITEBACK must swallow the pending write.
    do_ack(32'h00A00393, 0);           // addi x7,x0,10
    repeat (2) begin @(negedge clk); #1; end
    chk("wb_before_rst", rf_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("wb_rst_no_pulse", {rf_we, dm_we}, 2'b00);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 64'd0;
    #1;
    chk("wb_rst_refetch", {imem_req, imem_addr}, {1'b1, 64'd0});
    run_instr(32'h00500093, 1'b0, 0);

    run_trap(32'h00000000);
    run_trap(32'h022081B3);             // mul: unsupported funct7
    r = $urandom;
    run_trap({r[31:7], 7'b0110111});    // lui
    run_instr(gen_instr(), 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
